// File: rtl/fir_pkg.sv
// Shared constants, state encoding and width helpers for the symmetric FIR filter.
// FIR_NORM_EN selects the rounded/saturated DATA_W-wide output.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } fir_state_t;

    localparam int FIR_NCOEFS = 11;
    localparam int FIR_COEFS [FIR_NCOEFS] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

`ifdef FIR_NORM_EN
    localparam bit FIR_NORM = 1'b1;
`else
    localparam bit FIR_NORM = 1'b0;
`endif

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int fir_nmac(input int taps);
        return (taps + 1) / 2;
    endfunction

    function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + 1 + coef_w + clog2(fir_nmac(taps));
    endfunction

    function automatic int fir_out_w(input int data_w, input int coef_w, input int taps);
        return FIR_NORM ? data_w : fir_acc_w(data_w, coef_w, taps);
    endfunction

    function automatic int fir_ch_w(input int ch);
        return (ch > 1) ? clog2(ch) : 1;
    endfunction

    // Half-set beyond the stored table reads as zero so longer filters still elaborate.
    function automatic int fir_coef(input int i);
        if (i >= 0 && i < FIR_NCOEFS) return FIR_COEFS[4'(i)];
        return 0;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Per-channel sample shift registers; presents the folded tap pair x[idx] and
// x[TAPS-1-idx] of the selected channel.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAPS   = 22,
    parameter int CH     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift,
    input  logic [fir_ch_w(CH)-1:0] shift_ch,
    input  logic [DATA_W-1:0]       din,
    input  logic [fir_ch_w(CH)-1:0] sel_ch,
    input  logic [clog2(TAPS)-1:0]  idx,
    output logic [DATA_W-1:0]       tap_lo,
    output logic [DATA_W-1:0]       tap_hi
);
    localparam int CH_W  = fir_ch_w(CH);
    localparam int IDX_W = clog2(TAPS);

    logic [DATA_W-1:0] line [CH][TAPS];
    logic [IDX_W-1:0]  idx_hi;

    assign idx_hi = IDX_W'(TAPS - 1) - idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < TAPS; k++)
                    line[c][k] <= '0;
        end else if (shift) begin
            for (int c = 0; c < CH; c++) begin
                if (CH_W'(c) == shift_ch) begin
                    line[c][0] <= din;
                    for (int k = 1; k < TAPS; k++)
                        line[c][k] <= line[c][k-1];
                end
            end
        end
    end

    always_comb begin
        tap_lo = '0;
        tap_hi = '0;
        for (int c = 0; c < CH; c++) begin
            if (CH_W'(c) == sel_ch) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (IDX_W'(k) == idx)    tap_lo = line[c][k];
                    if (IDX_W'(k) == idx_hi) tap_hi = line[c][k];
                end
            end
        end
    end

endmodule

// File: rtl/fir_sym_mac.sv
// Multi-channel symmetric FIR: one shared multiplier walks the folded coefficient
// pairs, one pair per cycle. FIR_NORM_EN enables rounding/saturation to DATA_W.
module fir_sym_mac
    import fir_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 8,
    parameter int TAPS       = 22,
    parameter int CH         = 2,
    parameter int NORM_SHIFT = 10
) (
    input  logic                                       CLK_Filter,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    input  logic [fir_ch_w(CH)-1:0]                    in_ch,
    input  logic [DATA_W-1:0]                          in_data,
    output logic                                       in_ready,
    output logic                                       out_valid,
    output logic [fir_ch_w(CH)-1:0]                    out_ch,
    output logic [fir_out_w(DATA_W, COEF_W, TAPS)-1:0] out_data,
    output logic                                       busy
);
    localparam int  NMAC   = fir_nmac(TAPS);
    localparam int  ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);
    localparam int  OUT_W  = fir_out_w(DATA_W, COEF_W, TAPS);
    localparam int  CH_W   = fir_ch_w(CH);
    localparam int  IDX_W  = clog2(TAPS);
    localparam int  PROD_W = DATA_W + COEF_W + 1;
    localparam bit  ODD    = (TAPS % 2) == 1;

    if (TAPS < 2 || TAPS > 64 || CH < 1 || NORM_SHIFT < 1) begin : g_param_check
        $error("fir_sym_mac: unsupported parameter set");
    end

    fir_state_t          state_q, state_d;
    logic                accept;
    logic                ch_ok;
    logic                last;
    logic                centre;
    logic [IDX_W-1:0]    idx_q;
    logic [CH_W-1:0]     ch_q;
    logic [ACC_W-1:0]    acc_q;
    logic [DATA_W-1:0]   tap_lo, tap_hi;
    logic [DATA_W:0]     pair;
    logic [COEF_W-1:0]   coef_cur;
    logic [PROD_W-1:0]   prod;

    function automatic logic [OUT_W-1:0] normalise(input logic [ACC_W-1:0] a);
`ifdef FIR_NORM_EN
        logic [ACC_W:0] r;
        r = ({1'b0, a} + ((ACC_W+1)'(1) << (NORM_SHIFT - 1))) >> NORM_SHIFT;
        if (r > (ACC_W+1)'((1 << DATA_W) - 1)) return '1;
        return OUT_W'(r);
`else
        return a;
`endif
    endfunction

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .CH     (CH)
    ) u_line (
        .clk      (CLK_Filter),
        .rst_n    (rst_n),
        .shift    (accept),
        .shift_ch (in_ch),
        .din      (in_data),
        .sel_ch   (ch_q),
        .idx      (idx_q),
        .tap_lo   (tap_lo),
        .tap_hi   (tap_hi)
    );

    assign ch_ok  = 32'(in_ch) < CH;
    assign last   = idx_q == IDX_W'(NMAC - 1);
    assign centre = ODD && last;

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && ch_ok) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pair fold: the odd-length centre tap is counted once, not doubled.
    always_comb begin
        coef_cur = '0;
        for (int k = 0; k < NMAC; k++)
            if (IDX_W'(k) == idx_q) coef_cur = COEF_W'(fir_coef(k));
        pair = centre ? {1'b0, tap_lo} : ({1'b0, tap_lo} + {1'b0, tap_hi});
        prod = PROD_W'(pair) * PROD_W'(coef_cur);
    end

    // Accumulate during MAC; publish the normalised result as a one-cycle pulse.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            idx_q     <= '0;
            ch_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                acc_q <= '0;
                idx_q <= '0;
                ch_q  <= in_ch;
            end else if (state_q == MAC) begin
                acc_q <= acc_q + ACC_W'(prod);
                idx_q <= idx_q + IDX_W'(1);
            end else if (state_q == DONE) begin
                out_valid <= 1'b1;
                out_data  <= normalise(acc_q);
                out_ch    <= ch_q;
            end
        end
    end

endmodule

// File: tb/tb_fir_sym_mac.sv
// Scoreboard bench for fir_sym_mac: a direct-form reference model pushes expected
// results on every accepted sample; each scenario pops and compares them inline.
module tb_fir_sym_mac;
    import fir_pkg::*;

    localparam int DW     = 8;
    localparam int CW     = 8;
    localparam int TAPS_A = 22;
    localparam int CH_A   = 2;
    localparam int TAPS_B = 5;
    localparam int CH_B   = 3;
    localparam int OW_A   = fir_out_w(DW, CW, TAPS_A);
    localparam int OW_B   = fir_out_w(DW, CW, TAPS_B);
    localparam int CHW_A  = fir_ch_w(CH_A);
    localparam int CHW_B  = fir_ch_w(CH_B);

`ifdef FIR_NORM_EN
    localparam longint DC_FINAL  = 135;
    localparam longint SAT_FINAL = 255;
`else
    localparam longint DC_FINAL  = 138600;
    localparam longint SAT_FINAL = 353430;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid_a = 1'b0, in_ready_a, out_valid_a, busy_a;
    logic [CHW_A-1:0] in_ch_a = '0, out_ch_a;
    logic [DW-1:0]    in_data_a = '0;
    logic [OW_A-1:0]  out_data_a;

    logic             in_valid_b = 1'b0, in_ready_b, out_valid_b, busy_b;
    logic [CHW_B-1:0] in_ch_b = '0, out_ch_b;
    logic [DW-1:0]    in_data_b = '0;
    logic [OW_B-1:0]  out_data_b;

    fir_sym_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS_A), .CH(CH_A), .NORM_SHIFT(10)) dut_a (
        .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ch(in_ch_a),
        .in_data(in_data_a), .in_ready(in_ready_a), .out_valid(out_valid_a),
        .out_ch(out_ch_a), .out_data(out_data_a), .busy(busy_a));

    fir_sym_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS_B), .CH(CH_B), .NORM_SHIFT(10)) dut_b (
        .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ch(in_ch_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
        .out_ch(out_ch_b), .out_data(out_data_b), .busy(busy_b));

    typedef struct {
        int     ch;
        longint data;
    } exp_t;

    exp_t   sbq [$];
    int     coef_ref [11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
    int     taps_of [2]   = '{TAPS_A, TAPS_B};
    int     ch_of [2]     = '{CH_A, CH_B};
    longint hist [2][3][22];
    int     vectors = 0;
    int     miscompares = 0;
    int     pulses_a = 0;
    int     pulses_b = 0;

    always @(negedge clk) begin
        if (out_valid_a === 1'b1) pulses_a <= pulses_a + 1;
        if (out_valid_b === 1'b1) pulses_b <= pulses_b + 1;
    end

    function automatic longint norm(input longint acc);
`ifdef FIR_NORM_EN
        longint r;
        r = (acc + 512) >> 10;
        return (r > 255) ? 255 : r;
`else
        return acc;
`endif
    endfunction

    function automatic void model_clear();
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 22; k++)
                    hist[u][c][k] = 0;
        sbq.delete();
    endfunction

    // Direct-form convolution with the mirrored impulse response h[k] = c[min(k, T-1-k)].
    function automatic void model_accept(input int u, input int ch, input int d);
        int     t;
        longint acc;
        exp_t   e;
        t = taps_of[u];
        for (int k = t - 1; k > 0; k--) hist[u][ch][k] = hist[u][ch][k-1];
        hist[u][ch][0] = d;
        acc = 0;
        for (int k = 0; k < t; k++)
            acc += longint'(coef_ref[(k < t - 1 - k) ? k : t - 1 - k]) * hist[u][ch][k];
        e.ch   = ch;
        e.data = norm(acc);
        sbq.push_back(e);
    endfunction

    function automatic logic rdy(input int u);
        return (u == 0) ? in_ready_a : in_ready_b;
    endfunction

    function automatic logic ov(input int u);
        return (u == 0) ? out_valid_a : out_valid_b;
    endfunction

    function automatic int och(input int u);
        return (u == 0) ? int'(out_ch_a) : int'(out_ch_b);
    endfunction

    function automatic longint odat(input int u);
        return (u == 0) ? longint'(out_data_a) : longint'(out_data_b);
    endfunction

    task automatic drive(input int u, input int ch, input int d);
        int n;
        n = 0;
        while (rdy(u) !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy(u) !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, want 1", rdy(u), n);
            return;
        end
        if (u == 0) begin
            in_valid_a = 1'b1; in_ch_a = CHW_A'(ch); in_data_a = DW'(d);
        end else begin
            in_valid_b = 1'b1; in_ch_b = CHW_B'(ch); in_data_b = DW'(d);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        if (ch < ch_of[u]) model_accept(u, ch, d);
    endtask

    task automatic wait_out(input int u, output int lat, output bit seen);
        lat = 0;
        while (ov(u) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        seen = (ov(u) === 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        vectors++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b, want 1 0 0", in_ready_a, busy_a, out_valid_a);
        end
        vectors++;
        if (out_data_a !== '0 || out_ch_a !== '0) begin
            miscompares++;
            $display("FAIL reset_data: data=%0d ch=%0d, want 0 0", out_data_a, out_ch_a);
        end
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        vectors++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0 || out_valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b busy=%b valid_b=%b, want 1 0 0", in_ready_a, busy_a, out_valid_b);
        end
    endtask

    task automatic test_impulse();
        int   lat;
        bit   seen;
        exp_t e;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            drive(0, 0, (k == 0) ? 255 : 0);
            vectors++;
            if (k == 5) begin
                if (busy_a !== 1'b1 || in_ready_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_in_mac: busy=%b ready=%b, want 1 0", busy_a, in_ready_a);
                end
            end else if (busy_a !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_after_accept[%0d]: busy=%b, want 1", k, busy_a);
            end
            wait_out(0, lat, seen);
            e = sbq.pop_front();
            vectors++;
            if (!seen || och(0) != e.ch || odat(0) !== e.data) begin
                miscompares++;
                $display("FAIL impulse[%0d]: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", k, seen, och(0), odat(0), e.ch, e.data);
            end
            if (k == 0) begin
                vectors++;
                if (lat != 12) begin
                    miscompares++;
                    $display("FAIL latency: %0d cycles, want 12", lat);
                end
            end
        end
    endtask

    task automatic test_dc();
        int   lat;
        bit   seen;
        exp_t e;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            drive(0, 0, 100);
            wait_out(0, lat, seen);
            e = sbq.pop_front();
            vectors++;
            if (!seen || och(0) != e.ch || odat(0) !== e.data) begin
                miscompares++;
                $display("FAIL dc[%0d]: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", k, seen, och(0), odat(0), e.ch, e.data);
            end
        end
        vectors++;
        if (odat(0) !== DC_FINAL) begin
            miscompares++;
            $display("FAIL dc_final: data=%0d, want %0d", odat(0), DC_FINAL);
        end
    endtask

    task automatic test_saturation();
        int   lat;
        bit   seen;
        exp_t e;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            drive(0, 1, 255);
            wait_out(0, lat, seen);
            e = sbq.pop_front();
            vectors++;
            if (!seen || och(0) != e.ch || odat(0) !== e.data) begin
                miscompares++;
                $display("FAIL sat[%0d]: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", k, seen, och(0), odat(0), e.ch, e.data);
            end
        end
        vectors++;
        if (odat(0) !== SAT_FINAL || och(0) != 1) begin
            miscompares++;
            $display("FAIL sat_final: data=%0d ch=%0d, want %0d ch=1", odat(0), och(0), SAT_FINAL);
        end
    endtask

    task automatic test_isolation();
        int   lat;
        bit   seen;
        exp_t e;
        do_reset();
        for (int k = 0; k < 44; k++) begin
            drive(0, k % 2, (k % 2 == 0) ? 100 : 0);
            wait_out(0, lat, seen);
            e = sbq.pop_front();
            vectors++;
            if (!seen || och(0) != e.ch || odat(0) !== e.data || (e.ch == 1 && odat(0) != 0)) begin
                miscompares++;
                $display("FAIL isolation[%0d]: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", k, seen, och(0), odat(0), e.ch, e.data);
            end
            if (k == 42) begin
                vectors++;
                if (odat(0) !== DC_FINAL) begin
                    miscompares++;
                    $display("FAIL isolation_ch0_final: data=%0d, want %0d", odat(0), DC_FINAL);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   accepts, last_acc, p0, lat;
        bit   seen, took;
        exp_t e;
        do_reset();
        accepts  = 0;
        last_acc = -1;
        p0 = pulses_a;
        in_valid_a = 1'b1;
        in_ch_a    = '0;
        in_data_a  = 8'd37;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (out_valid_a === 1'b1) begin
                e = sbq.pop_front();
                vectors++;
                if (och(0) != e.ch || odat(0) !== e.data) begin
                    miscompares++;
                    $display("FAIL b2b_data: ch=%0d data=%0d, want ch=%0d data=%0d", och(0), odat(0), e.ch, e.data);
                end
            end
            took = (in_ready_a === 1'b1);
            if (took) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc != 13) begin
                        miscompares++;
                        $display("FAIL b2b_interval: %0d cycles, want 13", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
                model_accept(0, 0, int'(in_data_a));
            end
            @(posedge clk); #1;
            if (took) in_data_a = in_data_a + 8'd41;
        end
        in_valid_a = 1'b0;
        while (sbq.size() > 0) begin
            wait_out(0, lat, seen);
            e = sbq.pop_front();
            vectors++;
            if (!seen || och(0) != e.ch || odat(0) !== e.data) begin
                miscompares++;
                $display("FAIL b2b_drain: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", seen, och(0), odat(0), e.ch, e.data);
            end
            if (sbq.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (pulses_a - p0 != accepts) begin
            miscompares++;
            $display("FAIL b2b_pulses: %0d pulses, want %0d", pulses_a - p0, accepts);
        end
    endtask

    task automatic test_bad_channel();
        int p0;
        do_reset();
        p0 = pulses_b;
        drive(1, 3, 200);
        vectors++;
        if (in_ready_b !== 1'b1 || busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_ch_accept: ready=%b busy=%b, want 1 0", in_ready_b, busy_b);
        end
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (pulses_b != p0) begin
            miscompares++;
            $display("FAIL bad_ch_output: %0d pulses, want 0", pulses_b - p0);
        end
    endtask

    task automatic test_odd_taps();
        int   lat;
        bit   seen;
        exp_t e;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 2, (k == 0) ? 255 : 0);
            wait_out(1, lat, seen);
            e = sbq.pop_front();
            vectors++;
            if (!seen || och(1) != e.ch || odat(1) !== e.data) begin
                miscompares++;
                $display("FAIL odd[%0d]: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", k, seen, och(1), odat(1), e.ch, e.data);
            end
            if (k == 0) begin
                vectors++;
                if (lat != 4) begin
                    miscompares++;
                    $display("FAIL odd_latency: %0d cycles, want 4", lat);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int   p0, lat;
        bit   seen;
        exp_t e;
        do_reset();
        drive(0, 0, 255);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== '0) begin
            miscompares++;
            $display("FAIL mid_mac_reset: valid=%b busy=%b ready=%b data=%0d, want 0 0 1 0", out_valid_a, busy_a, in_ready_a, out_data_a);
        end
        p0 = pulses_a;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (pulses_a != p0) begin
            miscompares++;
            $display("FAIL mid_mac_no_output: %0d pulses, want 0", pulses_a - p0);
        end
        drive(0, 0, 255);
        wait_out(0, lat, seen);
        e = sbq.pop_front();
        vectors++;
        if (!seen || och(0) != e.ch || odat(0) !== e.data) begin
            miscompares++;
            $display("FAIL after_reset_impulse: valid=%b ch=%0d data=%0d, want ch=%0d data=%0d", seen, och(0), odat(0), e.ch, e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_isolation();
        test_back_to_back();
        test_bad_channel();
        test_odd_taps();
        test_reset_mid_mac();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
